// File: rtl/voice_pkg.sv
// Shared constants and types for the voice allocator.
// Holds the key and voice pool sizes, the voice record layout and a
// saturating age increment used by the allocator.
package voice_pkg;

    localparam int NUM_KEYS   = 24;
    localparam int NUM_VOICES = 8;
    localparam int AGE_W      = 16;
    localparam int KEY_W      = $clog2(NUM_KEYS);
    localparam int VOICE_W    = $clog2(NUM_VOICES);

    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef logic [KEY_W-1:0]   key_idx_t;
    typedef logic [VOICE_W-1:0] voice_idx_t;

    typedef struct packed {
        key_idx_t         note;
        logic             active;
        logic [AGE_W-1:0] age;
    } voice_t;

    // Age counter saturates so a very long held note stays "oldest"
    // instead of wrapping to look freshly started.
    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] age);
        return (age == AGE_MAX) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/voice_steal_select.sv
// Combinational voice pool scan.
// Ports:
//   voices     - current registered state of every voice
//   free_idx   - lowest-index inactive voice (valid when free_found)
//   free_found - at least one voice is inactive
//   oldest_idx - voice with the largest age, lowest index on ties
module voice_steal_select
    import voice_pkg::*;
(
    input  voice_t [NUM_VOICES-1:0] voices,
    output voice_idx_t              free_idx,
    output logic                    free_found,
    output voice_idx_t              oldest_idx
);

    logic [AGE_W-1:0] best_age;

    // NOTE: every output gets a default before the loops so no path leaves
    // a value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        // Scanning downward lets the lowest free index win.
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voices[v].active) begin
                free_found = 1'b1;
                free_idx   = voice_idx_t'(v);
            end
        end
    end

    always_comb begin
        best_age   = voices[0].age;
        oldest_idx = '0;
        // Strict greater-than keeps the lowest index on equal ages.
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (voices[v].age > best_age) begin
                best_age   = voices[v].age;
                oldest_idx = voice_idx_t'(v);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator.
// Captures key trigger pulses into a pending set, services one key per
// cycle (retrigger owner, else lowest free voice, else steal the oldest),
// and releases voices whose key gate has dropped.
// Ports:
//   clk_in            - system clock
//   rst_in            - synchronous active-high reset
//   gate_in           - per-key held level
//   trigger_in        - per-key single-cycle press pulse
//   voice_note_out    - key index owned by each voice
//   voice_active_out  - voice currently sounding
//   voice_trigger_out - one-cycle pulse, voice (re)started
//   voice_release_out - one-cycle pulse, voice released
//   steal_out         - one-cycle pulse, allocation stole an active voice
module voice_allocator
    import voice_pkg::*;
(
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic [NUM_KEYS-1:0]                gate_in,
    input  logic [NUM_KEYS-1:0]                trigger_in,
    output logic [NUM_VOICES-1:0][KEY_W-1:0]   voice_note_out,
    output logic [NUM_VOICES-1:0]              voice_active_out,
    output logic [NUM_VOICES-1:0]              voice_trigger_out,
    output logic [NUM_VOICES-1:0]              voice_release_out,
    output logic                               steal_out
);

    voice_t [NUM_VOICES-1:0] voices_q, voices_d;
    logic   [NUM_KEYS-1:0]   pending_q, pending_d, serviced;
    logic   [NUM_VOICES-1:0] trig_d, rel_d;
    logic                    steal_d;

    logic       pend_found;
    key_idx_t   sel_key;
    logic       owner_found;
    voice_idx_t owner_idx;
    voice_idx_t free_idx, oldest_idx, target_idx;
    logic       free_found;

    voice_steal_select u_select (
        .voices     (voices_q),
        .free_idx   (free_idx),
        .free_found (free_found),
        .oldest_idx (oldest_idx)
    );

    // Lowest-index pending key.
    always_comb begin
        pend_found = 1'b0;
        sel_key    = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (pending_q[k]) begin
                pend_found = 1'b1;
                sel_key    = key_idx_t'(k);
            end
        end
    end

    // Does an active voice already own the selected key?
    always_comb begin
        owner_found = 1'b0;
        owner_idx   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voices_q[v].active && voices_q[v].note == sel_key) begin
                owner_found = 1'b1;
                owner_idx   = voice_idx_t'(v);
            end
        end
    end

    always_comb begin
        target_idx = owner_found ? owner_idx : (free_found ? free_idx : oldest_idx);
        steal_d    = pend_found && !owner_found && !free_found;

        serviced = '0;
        serviced[sel_key] = pend_found;
        pending_d = (pending_q | trigger_in) & gate_in & ~serviced;

        // Decisions use the registered active vector, so a voice releasing
        // this cycle only becomes free for allocation next cycle.
        for (int v = 0; v < NUM_VOICES; v++) begin
            voices_d[v] = voices_q[v];
            trig_d[v]   = 1'b0;
            rel_d[v]    = 1'b0;
            if (pend_found && target_idx == voice_idx_t'(v)) begin
                // Allocation wins over release; a stolen voice never pulses release.
                if (!owner_found) begin
                    voices_d[v].note = sel_key;
                end
                voices_d[v].active = 1'b1;
                voices_d[v].age    = '0;
                trig_d[v]          = 1'b1;
            end else if (voices_q[v].active && !gate_in[voices_q[v].note]) begin
                voices_d[v].active = 1'b0;
                voices_d[v].age    = '0;
                rel_d[v]           = 1'b1;
            end else if (voices_q[v].active) begin
                voices_d[v].age = age_inc(voices_q[v].age);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the voice records are few flops, not a RAM,
    // so they are all reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            voices_q          <= '0;
            pending_q         <= '0;
            voice_trigger_out <= '0;
            voice_release_out <= '0;
            steal_out         <= 1'b0;
        end else begin
            voices_q          <= voices_d;
            pending_q         <= pending_d;
            voice_trigger_out <= trig_d;
            voice_release_out <= rel_d;
            steal_out         <= steal_d;
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note_out[v]   = voices_q[v].note;
            voice_active_out[v] = voices_q[v].active;
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: expected trigger and release
// events are queued as stimulus is driven and matched by a monitor.
module tb_voice_allocator;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [23:0] gate_in;
    logic [23:0] trigger_in;
    logic [7:0][4:0] voice_note_out;
    logic [7:0]  voice_active_out;
    logic [7:0]  voice_trigger_out;
    logic [7:0]  voice_release_out;
    logic        steal_out;

    voice_allocator dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .gate_in           (gate_in),
        .trigger_in        (trigger_in),
        .voice_note_out    (voice_note_out),
        .voice_active_out  (voice_active_out),
        .voice_trigger_out (voice_trigger_out),
        .voice_release_out (voice_release_out),
        .steal_out         (steal_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cyc;
        int voice;
        int note;
        bit steal;
    } ev_t;

    ev_t trig_exp[$];
    ev_t rel_exp[$];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic ev_t mk(input int c, input int v, input int n, input bit s);
        ev_t e;
        e.cyc = c; e.voice = v; e.note = n; e.steal = s;
        return e;
    endfunction

    // Monitor: outputs are sampled on the falling edge.
    ev_t e;
    always @(negedge clk_in) begin
        while (trig_exp.size() > 0 && trig_exp[0].cyc < cyc) begin
            check("trig_missed", 64'(cyc), 64'(trig_exp[0].cyc));
            void'(trig_exp.pop_front());
        end
        while (rel_exp.size() > 0 && rel_exp[0].cyc < cyc) begin
            check("rel_missed", 64'(cyc), 64'(rel_exp[0].cyc));
            void'(rel_exp.pop_front());
        end
        if (steal_out === 1'b1)
            check("steal_with_trig", 64'(voice_trigger_out != 8'h00), 64'd1);
        for (int v = 0; v < 8; v++) begin
            if (voice_trigger_out[v] === 1'b1) begin
                check("trig_expected", 64'(trig_exp.size() > 0), 64'd1);
                if (trig_exp.size() > 0) begin
                    e = trig_exp.pop_front();
                    check("trig_cyc", 64'(cyc), 64'(e.cyc));
                    check("trig_voice", 64'(v), 64'(e.voice));
                    check("trig_note", 64'(voice_note_out[v]), 64'(e.note));
                    check("trig_active", 64'(voice_active_out[v]), 64'd1);
                    check("trig_steal", 64'(steal_out), 64'(e.steal));
                end
            end
            if (voice_release_out[v] === 1'b1) begin
                check("rel_expected", 64'(rel_exp.size() > 0), 64'd1);
                if (rel_exp.size() > 0) begin
                    e = rel_exp.pop_front();
                    check("rel_cyc", 64'(cyc), 64'(e.cyc));
                    check("rel_voice", 64'(v), 64'(e.voice));
                    check("rel_note", 64'(voice_note_out[v]), 64'(e.note));
                    check("rel_active", 64'(voice_active_out[v]), 64'd0);
                end
            end
        end
    end

    task automatic drive_trig(input logic [23:0] mask, output int c);
        @(negedge clk_in);
        c = cyc;
        gate_in    = gate_in | mask;
        trigger_in = mask;
        @(negedge clk_in);
        trigger_in = '0;
    endtask

    task automatic drop(input logic [23:0] mask, output int c);
        @(negedge clk_in);
        c = cyc;
        gate_in = gate_in & ~mask;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_note"}, 64'(voice_note_out), 64'd0);
        check({tag, "_active"}, 64'(voice_active_out), 64'd0);
        check({tag, "_trig"}, 64'(voice_trigger_out), 64'd0);
        check({tag, "_rel"}, 64'(voice_release_out), 64'd0);
        check({tag, "_steal"}, 64'(steal_out), 64'd0);
    endtask

    initial begin
        int c;
        logic [23:0] one;
        rst_in     = 1'b1;
        gate_in    = '0;
        trigger_in = '0;
        idle(3);
        check_all_zero("reset");
        rst_in = 1'b0;

        // Single press of key 3.
        drive_trig(24'h000008, c);
        trig_exp.push_back(mk(c + 2, 0, 3, 1'b0));
        idle(5);

        // Release of key 3; nothing else active.
        drop(24'h000008, c);
        rel_exp.push_back(mk(c + 1, 0, 3, 1'b0));
        @(negedge clk_in);
        check("release_active_vec", 64'(voice_active_out), 64'd0);
        idle(3);

        // Three simultaneous presses are serviced one per cycle.
        drive_trig(24'h000224, c);
        trig_exp.push_back(mk(c + 2, 0, 2, 1'b0));
        trig_exp.push_back(mk(c + 3, 1, 5, 1'b0));
        trig_exp.push_back(mk(c + 4, 2, 9, 1'b0));
        idle(6);
        check("three_active_vec", 64'(voice_active_out), 64'h07);
        drop(24'h000224, c);
        rel_exp.push_back(mk(c + 1, 0, 2, 1'b0));
        rel_exp.push_back(mk(c + 1, 1, 5, 1'b0));
        rel_exp.push_back(mk(c + 1, 2, 9, 1'b0));
        idle(4);

        // Fill the pool, then steal the oldest voice.
        for (int k = 0; k < 8; k++) begin
            one = 24'h1 << k;
            drive_trig(one, c);
            trig_exp.push_back(mk(c + 2, k, k, 1'b0));
            idle(8);
        end
        check("pool_full", 64'(voice_active_out), 64'hFF);
        drive_trig(24'h001000, c);
        trig_exp.push_back(mk(c + 2, 0, 12, 1'b1));
        idle(4);
        check("steal_note", 64'(voice_note_out[0]), 64'd12);
        drop(24'hFFFFFF, c);
        rel_exp.push_back(mk(c + 1, 0, 12, 1'b0));
        for (int k = 1; k < 8; k++) rel_exp.push_back(mk(c + 1, k, k, 1'b0));
        idle(4);

        // Key 7 gate drops before its turn: it must be discarded.
        @(negedge clk_in);
        c = cyc;
        gate_in    = 24'h0000FF;
        trigger_in = 24'h0000FF;
        @(negedge clk_in);
        trigger_in = '0;
        gate_in[7] = 1'b0;
        for (int k = 0; k < 7; k++) trig_exp.push_back(mk(c + 2 + k, k, k, 1'b0));
        idle(12);
        check("short_gate_active", 64'(voice_active_out), 64'h7F);
        drop(24'h00007F, c);
        for (int k = 0; k < 7; k++) rel_exp.push_back(mk(c + 1, k, k, 1'b0));
        idle(4);

        // Reset with five voices sounding; gates drop in the same cycle.
        drive_trig(24'h007C00, c);
        for (int k = 0; k < 5; k++) trig_exp.push_back(mk(c + 2 + k, k, 10 + k, 1'b0));
        idle(8);
        check("pre_reset_active", 64'(voice_active_out), 64'h1F);
        @(negedge clk_in);
        rst_in  = 1'b1;
        gate_in = '0;
        @(negedge clk_in);
        check_all_zero("mid_reset");
        rst_in = 1'b0;
        idle(2);
        check_all_zero("post_reset");

        drive_trig(24'h000010, c);
        trig_exp.push_back(mk(c + 2, 0, 4, 1'b0));
        idle(4);
        drop(24'h000010, c);
        rel_exp.push_back(mk(c + 1, 0, 4, 1'b0));
        idle(5);

        check("trig_queue_empty", 64'(trig_exp.size()), 64'd0);
        check("rel_queue_empty", 64'(rel_exp.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
